// File: rtl/fp_mul_if.sv
// Operand/result stream bundle for fp_mul_pipe. The flags signal exists only
// when FPMUL_FLAGS_EN is defined.
interface fp_mul_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]   flags;
`endif

    modport master (
        output in_valid, num1, num2, out_ready,
`ifdef FPMUL_FLAGS_EN
        input  flags,
`endif
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, num1, num2, out_ready,
`ifdef FPMUL_FLAGS_EN
        output flags,
`endif
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (flush-to-zero, RNE) with
// valid/ready backpressure. Define FPMUL_FLAGS_EN to add the exception flags.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic     clk,
    input  logic     rst,
    fp_mul_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO    = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    logic advance;
    logic out_valid_reg;
    logic [W-1:0] product_reg, product_next;

    assign advance       = !out_valid_reg || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_reg;
    assign bus.product   = product_reg;

    // Operand unpack and classification
    logic [W-1:0]     op     [2];
    logic [EXP_W-1:0] exp_f  [2];
    logic [MAN_W-1:0] man_f  [2];
    logic [MAN_W:0]   sig_f  [2];
    logic [1:0]       is_zero, is_inf, is_nan;

    assign op[0] = bus.num1;
    assign op[1] = bus.num2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            assign exp_f[gi]   = op[gi][W-2 -: EXP_W];
            assign man_f[gi]   = op[gi][MAN_W-1:0];
            assign sig_f[gi]   = {1'b1, man_f[gi]};
            assign is_zero[gi] = (exp_f[gi] == '0);
            assign is_inf[gi]  = (exp_f[gi] == EXP_ONES) && (man_f[gi] == '0);
            assign is_nan[gi]  = (exp_f[gi] == EXP_ONES) && (man_f[gi] != '0);
        end
    endgenerate

    logic inf_times_zero;
    kind_t kind_next;
    logic signed [EW-1:0] exp_next;

    assign inf_times_zero = (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);
    assign exp_next = $signed({2'b00, exp_f[0]}) + $signed({2'b00, exp_f[1]}) - BIAS;

    always_comb begin
        kind_next = K_NORM;
        if (|is_nan || inf_times_zero)
            kind_next = K_NAN;
        else if (|is_inf)
            kind_next = K_INF;
        else if (|is_zero)
            kind_next = K_ZERO;
    end

    // Stage data registers; only the valid bits and the output need reset
    logic                 s1_valid_reg, s2_valid_reg;
    logic                 s1_sign_reg, s2_sign_reg;
    kind_t                s1_kind_reg, s2_kind_reg;
    logic signed [EW-1:0] s1_exp_reg, s2_exp_reg;
    logic [MAN_W:0]       s1_siga_reg, s1_sigb_reg;
    logic [PW-1:0]        s2_prod_reg;

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign_reg <= op[0][W-1] ^ op[1][W-1];
            s1_kind_reg <= kind_next;
            s1_exp_reg  <= exp_next;
            s1_siga_reg <= sig_f[0];
            s1_sigb_reg <= sig_f[1];
            s2_sign_reg <= s1_sign_reg;
            s2_kind_reg <= s1_kind_reg;
            s2_exp_reg  <= s1_exp_reg;
            s2_prod_reg <= PW'(s1_siga_reg) * PW'(s1_sigb_reg);
        end
    end

    // Normalise: frac holds the bits below the leading one, left-aligned
    logic [PW-2:0]        frac;
    logic [MAN_W-1:0]     mant;
    logic                 guard, sticky, round_up;
    logic [MAN_W:0]       rnd;
    logic signed [EW-1:0] exp_fin;
    logic                 ovf, unf;

    assign frac     = s2_prod_reg[PW-1] ? s2_prod_reg[PW-2:0] : {s2_prod_reg[PW-3:0], 1'b0};
    assign mant     = frac[PW-2 -: MAN_W];
    assign guard    = frac[PW-2-MAN_W];
    assign sticky   = |frac[PW-3-MAN_W:0];
    assign round_up = guard && (sticky || mant[0]);
    assign rnd      = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    // A rounding carry leaves rnd[MAN_W-1:0] all zero, i.e. exactly 1.0
    assign exp_fin  = s2_exp_reg + $signed({{(EW-1){1'b0}}, s2_prod_reg[PW-1]})
                                 + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
    assign ovf      = (s2_kind_reg == K_NORM) && (exp_fin >= EMAX);
    assign unf      = (s2_kind_reg == K_NORM) && !ovf && (exp_fin <= EZERO);

    always_comb begin
        product_next = '0;
        case (s2_kind_reg)
            K_NAN:   product_next = QNAN;
            K_INF:   product_next = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            K_ZERO:  product_next = {s2_sign_reg, {(W-1){1'b0}}};
            default: begin
                if (ovf)
                    product_next = {s2_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                else if (unf)
                    product_next = {s2_sign_reg, {(W-1){1'b0}}};
                else
                    product_next = {s2_sign_reg, exp_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
            end
        endcase
    end

`ifdef FPMUL_FLAGS_EN
    logic [1:0] snan;
    logic       s1_inv_reg, s2_inv_reg;
    logic [3:0] flags_reg, flags_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_snan
            assign snan[gi] = is_nan[gi] && !man_f[gi][MAN_W-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_inv_reg <= |snan || inf_times_zero;
            s2_inv_reg <= s1_inv_reg;
        end
    end

    assign flags_next = {(s2_kind_reg == K_NAN) && s2_inv_reg, ovf, unf,
                         ovf || unf || ((s2_kind_reg == K_NORM) && (guard || sticky))};
    assign bus.flags  = flags_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            product_reg   <= '0;
`ifdef FPMUL_FLAGS_EN
            flags_reg     <= '0;
`endif
        end else if (advance) begin
            s1_valid_reg  <= bus.in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                product_reg <= product_next;
`ifdef FPMUL_FLAGS_EN
                flags_reg   <= flags_next;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vector table, backpressure,
// random streaming against an integer reference model, and mid-flight reset.
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mul_if #(.EXP_W(8), .MAN_W(23)) bus_s ();
    fp_mul_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst(rst), .bus(bus_s.slave));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst(rst), .bus(bus_h.slave));

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        bit          hp;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact integer product, rounded by remainder comparison
    function automatic void model(input int ew, input int mw, input longint a, input longint b,
                                  output longint p, output logic [3:0] f);
        longint one = 1;
        longint emax = (one << ew) - 1;
        longint bias = (one << (ew - 1)) - 1;
        longint mmask = (one << mw) - 1;
        longint sa = (a >> (ew + mw)) & 1, sb = (b >> (ew + mw)) & 1;
        longint ea = (a >> mw) & emax, eb = (b >> mw) & emax;
        longint ma = a & mmask, mb = b & mmask;
        longint s = sa ^ sb;
        bit an = (ea == emax) && (ma != 0), bn = (eb == emax) && (mb != 0);
        bit ai = (ea == emax) && (ma == 0), bi = (eb == emax) && (mb == 0);
        bit az = (ea == 0), bz = (eb == 0);
        bit inv0 = (ai && bz) || (bi && az);
        longint prod, e, q, rem, half;
        int n, sh;
        f = 4'b0000;
        if (an || bn || inv0) begin
            p = (emax << mw) | (one << (mw - 1));
            f[3] = inv0 || (an && ((ma >> (mw - 1)) & 1) == 0) || (bn && ((mb >> (mw - 1)) & 1) == 0);
            return;
        end
        if (ai || bi) begin p = (s << (ew + mw)) | (emax << mw); return; end
        if (az || bz) begin p = s << (ew + mw); return; end
        prod = ((one << mw) | ma) * ((one << mw) | mb);
        n = ((prod >> (2 * mw + 1)) != 0) ? 2 * mw + 1 : 2 * mw;
        e = ea + eb - bias + (n - 2 * mw);
        sh = n - mw;
        q = prod >> sh;
        rem = prod & ((one << sh) - 1);
        half = one << (sh - 1);
        if (rem > half || (rem == half && (q & 1) == 1)) q++;
        if ((q >> (mw + 1)) != 0) begin q = q >> 1; e++; end
        if (e >= emax) begin p = (s << (ew + mw)) | (emax << mw); f = 4'b0101; end
        else if (e <= 0) begin p = s << (ew + mw); f = 4'b0011; end
        else begin p = (s << (ew + mw)) | (e << mw) | (q & mmask); f[0] = (rem != 0); end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] specials [8] = '{32'h0, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                                      32'h7F800001, 32'h00000005, 32'h7F7FFFFF, 32'h00800000};
        if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 7)];
        return {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom())};
    endfunction

    task automatic drive(input bit hp, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy);
        if (hp) begin
            bus_h.in_valid = iv; bus_h.num1 = a[15:0]; bus_h.num2 = b[15:0]; bus_h.out_ready = ordy;
        end else begin
            bus_s.in_valid = iv; bus_s.num1 = a; bus_s.num2 = b; bus_s.out_ready = ordy;
        end
    endtask

    task automatic sample(input bit hp, output logic ov, output logic ir, output logic [31:0] p,
                          output logic [3:0] f);
        f = 4'b0000;
        if (hp) begin
            ov = bus_h.out_valid; ir = bus_h.in_ready; p = {16'h0, bus_h.product};
`ifdef FPMUL_FLAGS_EN
            f = bus_h.flags;
`endif
        end else begin
            ov = bus_s.out_valid; ir = bus_s.in_ready; p = bus_s.product;
`ifdef FPMUL_FLAGS_EN
            f = bus_s.flags;
`endif
        end
    endtask

    task automatic run_single(input bit hp, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] p, output logic [3:0] f, output int lat);
        logic ov, ir;
        @(negedge clk); drive(hp, 1'b1, a, b, 1'b1);
        @(negedge clk); drive(hp, 1'b0, a, b, 1'b1);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            #1 sample(hp, ov, ir, p, f);
            if (ov) begin lat = i; break; end
            @(negedge clk);
        end
    endtask

    // mode 0: random valid/ready; mode 1: back-to-back issue, out_ready low for cycles 2..11
    task automatic stream(input int nops, input int mode);
        logic [31:0] q_p [$];
        logic [3:0]  q_f [$];
        int sent = 0, got = 0, cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] held = '0, a, b, p, ep;
        logic [3:0] f, ef;
        logic iv, ordy, ov, ir;
        longint mp;
        while (got < nops && cyc < 400) begin
            @(negedge clk);
            if (mode == 0) begin
                iv = (sent < nops) && ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 7);
            end else begin
                iv = (sent < nops);
                ordy = (cyc < 2) || (cyc >= 12);
            end
            a = rand_op(); b = rand_op();
            drive(1'b0, iv, a, b, ordy);
            #1 sample(1'b0, ov, ir, p, f);
            if (prev_stall) begin
                chk("hold_valid", 32'(ov), 32'd1);
                chk("hold_product", p, held);
            end
            if (ov && !ordy) chk("in_ready_stall", 32'(ir), 32'd0);
            prev_stall = ov && !ordy;
            held = p;
            if (ov && ordy) begin
                chk("result_expected", 32'(q_p.size() > 0), 32'd1);
                if (q_p.size() > 0) begin
                    ep = q_p.pop_front(); ef = q_f.pop_front();
                    chk("stream_product", p, ep);
`ifdef FPMUL_FLAGS_EN
                    chk("stream_flags", 32'(f), 32'(ef));
`endif
                    $display("stream op %0d: product %h expected %h", got, p, ep);
                    got++;
                end
            end
            if (iv && ir) begin
                model(8, 23, longint'(a), longint'(b), mp, ef);
                q_p.push_back(mp[31:0]); q_f.push_back(ef);
                sent++;
            end
            cyc++;
        end
        chk("stream_count", 32'(got), 32'(nops));
        @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        vec_t vecs [$];
        logic [31:0] p;
        logic [3:0] f;
        logic ov, ir;
        int lat, ghosts;

        vecs.push_back('{1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000});
        vecs.push_back('{1'b0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001});
        vecs.push_back('{1'b0, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001});
        vecs.push_back('{1'b0, 32'hC0000000, 32'h3FC00000, 32'hC0400000, 4'b0000});
        vecs.push_back('{1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
        vecs.push_back('{1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101});
        vecs.push_back('{1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
        vecs.push_back('{1'b0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000});
        vecs.push_back('{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
        vecs.push_back('{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000});
        vecs.push_back('{1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
        vecs.push_back('{1'b0, 32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000});
        vecs.push_back('{1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000});
        vecs.push_back('{1'b1, 32'h00003C00, 32'h0000C000, 32'h0000C000, 4'b0000});
        vecs.push_back('{1'b1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101});

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        repeat (3) @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            sample(h[0], ov, ir, p, f);
            chk("reset_out_valid", 32'(ov), 32'd0);
            chk("reset_product", p, 32'd0);
`ifdef FPMUL_FLAGS_EN
            chk("reset_flags", 32'(f), 32'd0);
`endif
        end
        rst = 1'b0;
        #1;
        for (int h = 0; h < 2; h++) begin
            sample(h[0], ov, ir, p, f);
            chk("release_in_ready", 32'(ir), 32'd1);
        end

        foreach (vecs[i]) begin
            run_single(vecs[i].hp, vecs[i].a, vecs[i].b, p, f, lat);
            $display("vec %0d: %h x %h -> %h (expected %h) latency %0d", i, vecs[i].a, vecs[i].b,
                     p, vecs[i].p, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_product", i), p, vecs[i].p);
`ifdef FPMUL_FLAGS_EN
            chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
`endif
        end

        stream(6, 1);
        stream(40, 0);

        // Three ops in flight, then reset while the first sits unconsumed at the output
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b0, 1'b1, rand_op(), rand_op(), 1'b1);
        end
        @(negedge clk); drive(1'b0, 1'b0, '0, '0, 1'b0); rst = 1'b1;
        @(negedge clk); rst = 1'b0; drive(1'b0, 1'b0, '0, '0, 1'b1);
        #1 sample(1'b0, ov, ir, p, f);
        chk("midrst_out_valid", 32'(ov), 32'd0);
        chk("midrst_product", p, 32'd0);
        chk("midrst_in_ready", 32'(ir), 32'd1);
        ghosts = 0;
        repeat (8) begin
            @(negedge clk); #1 sample(1'b0, ov, ir, p, f);
            if (ov) ghosts++;
        end
        chk("midrst_no_results", 32'(ghosts), 32'd0);
        $display("mid-flight reset: out_valid %0d, product %h, late results %0d", ov, p, ghosts);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
